// File: rtl/keypad_unit_pkg.sv
// Shared constants, scanner state encoding and helpers for the keypad unit.
// Key codes are the raw scan position row*4+col of a standard 4x4 keypad.
package keypad_unit_pkg;

  localparam int ISA_WIDTH = 32;
  localparam logic [3:0] MAX_DIGITS = 4'd9;

  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_7    = 4'd8;
  localparam logic [3:0] KEY_8    = 4'd9;
  localparam logic [3:0] KEY_9    = 4'd10;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_0    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } scan_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    logic r;
    case (code)
      KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
      KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] key_digit(input logic [3:0] code);
    logic [3:0] d;
    case (code)
      KEY_1:   d = 4'd1;
      KEY_2:   d = 4'd2;
      KEY_3:   d = 4'd3;
      KEY_4:   d = 4'd4;
      KEY_5:   d = 4'd5;
      KEY_6:   d = 4'd6;
      KEY_7:   d = 4'd7;
      KEY_8:   d = 4'd8;
      KEY_9:   d = 4'd9;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // buffer*10 + digit without a general multiplier
  function automatic logic [ISA_WIDTH-1:0] append_digit(input logic [ISA_WIDTH-1:0] value,
                                                        input logic [3:0] digit);
    return (value << 3) + (value << 1) + ISA_WIDTH'(digit);
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    logic [3:0] drv;
    case (col)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = 4'b1110;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/keypad_unit_if.sv
// CPU-facing signals of the keypad unit: load handshake, pause control, display info.
interface keypad_unit_if;
  import keypad_unit_pkg::*;

  logic                 keypad_read_enable;
  logic                 keypad_read_complete;
  logic [ISA_WIDTH-1:0] keypad_data;
  logic                 cpu_pause;
  logic                 cpu_resume;
  logic [3:0]           key_code;
  logic [3:0]           digit_cnt;

  modport slave (
    input  keypad_read_enable,
    output keypad_read_complete, keypad_data, cpu_pause, cpu_resume, key_code, digit_cnt
  );

  modport master (
    output keypad_read_enable,
    input  keypad_read_complete, keypad_data, cpu_pause, cpu_resume, key_code, digit_cnt
  );
endinterface

// File: rtl/keypad_scanner.sv
// Column scanner with row synchroniser and press/release debounce; emits one
// key_valid pulse per accepted press. SCAN_DIV must be at least 3.
module keypad_scanner
  import keypad_unit_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_DIV - 1);
  // rows reflect a newly driven column only after the two synchroniser stages
  localparam logic [SW-1:0] SCAN_SETTLE = SW'(2);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    row_meta_r, row_sync_r;
  scan_state_e   state_r, state_nxt_s;
  logic [SW-1:0] scan_cnt_r, scan_cnt_nxt_s;
  logic [DW-1:0] db_cnt_r, db_cnt_nxt_s;
  logic [1:0]    col_r, col_nxt_s;
  logic [3:0]    pat_r, pat_nxt_s;
  logic          event_s;
  logic [3:0]    event_code_s;
  logic [3:0]    col_out_r;
  logic          key_valid_r;
  logic [3:0]    key_code_r;

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row_in;
      row_sync_r <= row_meta_r;
    end
  end

  // Next-state and counter logic for the scan/debounce/release FSM
  always_comb begin
    state_nxt_s    = state_r;
    scan_cnt_nxt_s = scan_cnt_r;
    db_cnt_nxt_s   = db_cnt_r;
    col_nxt_s      = col_r;
    pat_nxt_s      = pat_r;
    event_s        = 1'b0;
    event_code_s   = {low_row(pat_r), col_r};
    case (state_r)
      ST_SCAN: begin
        if ((scan_cnt_r >= SCAN_SETTLE) && (row_sync_r != 4'hF)) begin
          state_nxt_s  = ST_DEBOUNCE;
          pat_nxt_s    = row_sync_r;
          db_cnt_nxt_s = {DW{1'b0}};
        end else if (scan_cnt_r == SCAN_LAST) begin
          scan_cnt_nxt_s = {SW{1'b0}};
          col_nxt_s      = col_r + 2'd1;
        end else begin
          scan_cnt_nxt_s = scan_cnt_r + SW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_sync_r != pat_r) begin
          state_nxt_s    = ST_SCAN;
          scan_cnt_nxt_s = {SW{1'b0}};
          db_cnt_nxt_s   = {DW{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
          event_s      = 1'b1;
          state_nxt_s  = ST_RELEASE;
          db_cnt_nxt_s = {DW{1'b0}};
        end else begin
          db_cnt_nxt_s = db_cnt_r + DW'(1);
        end
      end
      ST_RELEASE: begin
        if (row_sync_r != 4'hF) begin
          db_cnt_nxt_s = {DW{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
          state_nxt_s    = ST_SCAN;
          scan_cnt_nxt_s = {SW{1'b0}};
          db_cnt_nxt_s   = {DW{1'b0}};
        end else begin
          db_cnt_nxt_s = db_cnt_r + DW'(1);
        end
      end
      default: begin
        state_nxt_s    = ST_SCAN;
        scan_cnt_nxt_s = {SW{1'b0}};
        db_cnt_nxt_s   = {DW{1'b0}};
        col_nxt_s      = 2'd0;
      end
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_SCAN;
      scan_cnt_r  <= {SW{1'b0}};
      db_cnt_r    <= {DW{1'b0}};
      col_r       <= 2'd0;
      pat_r       <= 4'hF;
      col_out_r   <= 4'b1110;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      scan_cnt_r  <= scan_cnt_nxt_s;
      db_cnt_r    <= db_cnt_nxt_s;
      col_r       <= col_nxt_s;
      pat_r       <= pat_nxt_s;
      col_out_r   <= col_drive(col_nxt_s);
      key_valid_r <= event_s;
      if (event_s) begin
        key_code_r <= event_code_s;
      end
    end
  end

  assign col_out   = col_out_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;

endmodule

// File: rtl/keypad_unit.sv
// Keypad entry unit: decimal entry buffer, enter/clear, pause toggle.
// Optional `KEYPAD_NEGATIVE_EN adds a sign key (C) applied on enter.
module keypad_unit
  import keypad_unit_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    row_in,
  output logic [3:0]    col_out,
  keypad_unit_if.slave  kif
);

  logic                 key_valid_s;
  logic [3:0]           scan_code_s;
  logic [ISA_WIDTH-1:0] buf_r, buf_nxt_s, entry_value_s;
  logic [ISA_WIDTH-1:0] data_r, data_nxt_s;
  logic [3:0]           cnt_r, cnt_nxt_s;
  logic [3:0]           code_r, code_nxt_s;
  logic                 complete_r, complete_nxt_s;
  logic                 pause_r, pause_nxt_s;
  logic                 paused_r, paused_nxt_s;
  logic                 resume_r, resume_nxt_s;
`ifdef KEYPAD_NEGATIVE_EN
  logic                 sign_r, sign_nxt_s;
`endif

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid_s),
    .key_code  (scan_code_s)
  );

  // Value delivered on enter, with the optional sign applied
  always_comb begin
`ifdef KEYPAD_NEGATIVE_EN
    if (sign_r) begin
      entry_value_s = ISA_WIDTH'(0) - buf_r;
    end else begin
      entry_value_s = buf_r;
    end
`else
    entry_value_s = buf_r;
`endif
  end

  // Key event decode into entry buffer, enter and pause actions
  always_comb begin
    buf_nxt_s      = buf_r;
    cnt_nxt_s      = cnt_r;
    data_nxt_s     = data_r;
    code_nxt_s     = code_r;
    complete_nxt_s = 1'b0;
    pause_nxt_s    = 1'b0;
    paused_nxt_s   = paused_r;
    resume_nxt_s   = resume_r;
`ifdef KEYPAD_NEGATIVE_EN
    sign_nxt_s     = sign_r;
`endif
    if (key_valid_s) begin
      code_nxt_s = scan_code_s;
      if (is_digit(scan_code_s)) begin
        if (kif.keypad_read_enable && (cnt_r < MAX_DIGITS)) begin
          buf_nxt_s = append_digit(buf_r, key_digit(scan_code_s));
          cnt_nxt_s = cnt_r + 4'd1;
        end else begin
          buf_nxt_s = buf_r;
        end
      end else begin
        case (scan_code_s)
          KEY_A: begin
            paused_nxt_s = ~paused_r;
            pause_nxt_s  = ~paused_r;
            resume_nxt_s = paused_r;
          end
          KEY_B: begin
            if (kif.keypad_read_enable) begin
              buf_nxt_s  = {ISA_WIDTH{1'b0}};
              cnt_nxt_s  = 4'd0;
`ifdef KEYPAD_NEGATIVE_EN
              sign_nxt_s = 1'b0;
`endif
            end else begin
              buf_nxt_s = buf_r;
            end
          end
          KEY_C: begin
`ifdef KEYPAD_NEGATIVE_EN
            if (kif.keypad_read_enable) begin
              sign_nxt_s = ~sign_r;
            end else begin
              sign_nxt_s = sign_r;
            end
`endif
          end
          KEY_D: begin
            if (kif.keypad_read_enable) begin
              data_nxt_s     = entry_value_s;
              complete_nxt_s = 1'b1;
              buf_nxt_s      = {ISA_WIDTH{1'b0}};
              cnt_nxt_s      = 4'd0;
`ifdef KEYPAD_NEGATIVE_EN
              sign_nxt_s     = 1'b0;
`endif
            end else begin
              data_nxt_s = data_r;
            end
          end
          default: begin
            buf_nxt_s = buf_r;
          end
        endcase
      end
    end else begin
      code_nxt_s = code_r;
    end
  end

  // Entry, pause and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r      <= {ISA_WIDTH{1'b0}};
      cnt_r      <= 4'd0;
      data_r     <= {ISA_WIDTH{1'b0}};
      code_r     <= 4'd0;
      complete_r <= 1'b0;
      pause_r    <= 1'b0;
      paused_r   <= 1'b0;
      resume_r   <= 1'b1;
`ifdef KEYPAD_NEGATIVE_EN
      sign_r     <= 1'b0;
`endif
    end else begin
      buf_r      <= buf_nxt_s;
      cnt_r      <= cnt_nxt_s;
      data_r     <= data_nxt_s;
      code_r     <= code_nxt_s;
      complete_r <= complete_nxt_s;
      pause_r    <= pause_nxt_s;
      paused_r   <= paused_nxt_s;
      resume_r   <= resume_nxt_s;
`ifdef KEYPAD_NEGATIVE_EN
      sign_r     <= sign_nxt_s;
`endif
    end
  end

  assign kif.keypad_read_complete = complete_r;
  assign kif.keypad_data          = data_r;
  assign kif.cpu_pause            = pause_r;
  assign kif.cpu_resume           = resume_r;
  assign kif.key_code             = code_r;
  assign kif.digit_cnt            = cnt_r;

endmodule

// File: tb/tb_keypad_unit.sv
// Directed bench for keypad_unit with a behavioural 4x4 keypad model.
module tb_keypad_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_down = 1'b0;
  logic [1:0]  key_row = 2'd0;
  logic [1:0]  key_col = 2'd0;

  int checks = 0;
  int errors = 0;
  int comp_cnt = 0;
  int pause_cnt = 0;
  int bad_pulse = 0;
  logic comp_prev = 1'b0;
  logic pause_prev = 1'b0;

  localparam logic [3:0] K1 = 4'd0,  K2 = 4'd1,  K3 = 4'd2,  KA = 4'd3;
  localparam logic [3:0] K4 = 4'd4,  K5 = 4'd5,  K6 = 4'd6,  KB = 4'd7;
  localparam logic [3:0] K7 = 4'd8,  K8 = 4'd9,  K9 = 4'd10, KC = 4'd11;
  localparam logic [3:0] KD = 4'd15;

  keypad_unit_if kif ();

  keypad_unit #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .kif     (kif)
  );

  always #5 clk = ~clk;

  // keypad switch matrix: a held key pulls its row low while its column is driven
  always_comb begin
    row_in = 4'hF;
    if (key_down && (col_out[key_col] == 1'b0)) row_in[key_row] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (kif.keypad_read_complete) comp_cnt++;
      if (kif.cpu_pause) pause_cnt++;
      if ((kif.keypad_read_complete && kif.cpu_pause) ||
          (kif.cpu_pause && kif.cpu_resume) ||
          (kif.keypad_read_complete && comp_prev) ||
          (kif.cpu_pause && pause_prev)) bad_pulse++;
    end
    comp_prev  = kif.keypad_read_complete;
    pause_prev = kif.cpu_pause;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic press_key(input logic [3:0] code);
    @(negedge clk);
    key_row  = code[3:2];
    key_col  = code[1:0];
    key_down = 1'b1;
    repeat (40) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int c0;
    int p0;
    logic [3:0] col_before;
    logic rotated;

    kif.keypad_read_enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_col", {28'd0, col_out}, 32'h0000000E);
    check_eq("rst_data", kif.keypad_data, 32'd0);
    check_eq("rst_resume", {31'd0, kif.cpu_resume}, 32'd1);
    check_eq("rst_pause", {31'd0, kif.cpu_pause}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1,2,3,D
    kif.keypad_read_enable = 1'b1;
    c0 = comp_cnt;
    press_key(K1); press_key(K2); press_key(K3);
    check_eq("cnt_123", {28'd0, kif.digit_cnt}, 32'd3);
    press_key(KD);
    check_eq("comp_123", comp_cnt, c0 + 1);
    check_eq("data_123", kif.keypad_data, 32'd123);
    check_eq("cnt_after_d", {28'd0, kif.digit_cnt}, 32'd0);
    check_eq("code_d", {28'd0, kif.key_code}, 32'd15);

    // short bounce on 5
    @(negedge clk);
    key_row = K5[3:2]; key_col = K5[1:0]; key_down = 1'b1;
    repeat (6) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("bounce_code", {28'd0, kif.key_code}, 32'd15);
    check_eq("bounce_cnt", {28'd0, kif.digit_cnt}, 32'd0);
    col_before = col_out;
    rotated = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (col_out != col_before) rotated = 1'b1;
    end
    check_eq("bounce_rotate", {31'd0, rotated}, 32'd1);

    // pause toggle
    p0 = pause_cnt;
    press_key(KA);
    check_eq("pause_pulse", pause_cnt, p0 + 1);
    check_eq("paused_resume", {31'd0, kif.cpu_resume}, 32'd0);
    check_eq("code_a", {28'd0, kif.key_code}, 32'd3);
    press_key(KA);
    check_eq("unpaused_resume", {31'd0, kif.cpu_resume}, 32'd1);
    check_eq("pause_once", pause_cnt, p0 + 1);

    // ten nines
    for (int i = 0; i < 10; i++) press_key(K9);
    check_eq("cnt_limit", {28'd0, kif.digit_cnt}, 32'd9);
    press_key(KD);
    check_eq("data_nines", kif.keypad_data, 32'd999999999);

    // sign key
    press_key(K4); press_key(KC); press_key(KD);
`ifdef KEYPAD_NEGATIVE_EN
    check_eq("data_sign", kif.keypad_data, 32'hFFFFFFFC);
`else
    check_eq("data_sign", kif.keypad_data, 32'h00000004);
`endif

    // keys with read_enable low
    kif.keypad_read_enable = 1'b0;
    c0 = comp_cnt;
    press_key(K5);
    check_eq("off_code", {28'd0, kif.key_code}, 32'd5);
    check_eq("off_cnt", {28'd0, kif.digit_cnt}, 32'd0);
    press_key(KD);
    check_eq("off_comp", comp_cnt, c0);

    // buffer retained across read_enable drop
    kif.keypad_read_enable = 1'b1;
    press_key(K1);
    kif.keypad_read_enable = 1'b0;
    press_key(K2);
    kif.keypad_read_enable = 1'b1;
    press_key(K3);
    check_eq("retain_cnt", {28'd0, kif.digit_cnt}, 32'd2);
    press_key(KD);
    check_eq("retain_data", kif.keypad_data, 32'd13);

    // clear
    press_key(K6); press_key(KB);
    check_eq("clear_cnt", {28'd0, kif.digit_cnt}, 32'd0);
    press_key(K7); press_key(KD);
    check_eq("clear_data", kif.keypad_data, 32'd7);

    // reset mid-entry and mid-press
    press_key(K7); press_key(K8);
    check_eq("pre_rst_cnt", {28'd0, kif.digit_cnt}, 32'd2);
    @(negedge clk);
    key_row = K4[3:2]; key_col = K4[1:0]; key_down = 1'b1;
    repeat (25) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_col", {28'd0, col_out}, 32'h0000000E);
    check_eq("arst_cnt", {28'd0, kif.digit_cnt}, 32'd0);
    check_eq("arst_data", kif.keypad_data, 32'd0);
    check_eq("arst_code", {28'd0, kif.key_code}, 32'd0);
    check_eq("arst_resume", {31'd0, kif.cpu_resume}, 32'd1);
    check_eq("arst_comp", {31'd0, kif.keypad_read_complete}, 32'd0);
    key_down = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c0 = comp_cnt;
    press_key(K9); press_key(KD);
    check_eq("post_rst_data", kif.keypad_data, 32'd9);
    check_eq("post_rst_comp", comp_cnt, c0 + 1);

    check_eq("pulse_shape", bad_pulse, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
